// File: rtl/easy_fifo_wr_packer_if.sv
// Stream-in / FIFO-write bundle for easy_fifo_wr_packer.
// slave: packer side; master: the source of beats and the FIFO full flag.
interface easy_fifo_wr_packer_if #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned RATIO    = 4
);
    localparam int unsigned DWIDTH  = IN_WIDTH * RATIO;
    localparam int unsigned LANES_W = $clog2(RATIO + 1);

    logic [IN_WIDTH-1:0] s_data;
    logic                s_valid;
    logic                s_last;
    logic                s_ready;
    logic [DWIDTH-1:0]   fifo_wr_data;
    logic                fifo_wr_en;
    logic                fifo_wr_full;
    logic [LANES_W-1:0]  fifo_lanes;

    modport slave (
        input  s_data, s_valid, s_last, fifo_wr_full,
        output s_ready, fifo_wr_data, fifo_wr_en, fifo_lanes
    );

    modport master (
        output s_data, s_valid, s_last, fifo_wr_full,
        input  s_ready, fifo_wr_data, fifo_wr_en, fifo_lanes
    );
endinterface

// File: rtl/easy_fifo_wr_packer.sv
// Write-side packer for the dual-clock FIFO: gathers RATIO narrow beats into
// one word, flushes early on s_last (upper lanes zero), and parks the finished
// word in a single holding register until the FIFO accepts it.
// Optional: `define WR_PACKER_WORD_CNT_EN adds a 32-bit wr_word_cnt output
// counting FIFO writes.
module easy_fifo_wr_packer #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned RATIO    = 4
) (
    input  logic                    rst,
    input  logic                    wr_clk_int,
    easy_fifo_wr_packer_if.slave    bus
`ifdef WR_PACKER_WORD_CNT_EN
    ,
    output logic [31:0]             wr_word_cnt
`endif
);
    localparam int unsigned DWIDTH  = IN_WIDTH * RATIO;
    localparam int unsigned LANE_W  = $clog2(RATIO);
    localparam int unsigned LANES_W = $clog2(RATIO + 1);

    if (RATIO < 2) begin : g_bad_ratio
        $error("easy_fifo_wr_packer: RATIO must be >= 2");
    end

    typedef enum logic {
        ST_OPEN = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DWIDTH-1:0]   r_acc;
    logic [DWIDTH-1:0]   w_acc_nxt;
    logic [LANE_W-1:0]   r_lane;
    logic [LANE_W-1:0]   w_lane_nxt;
    logic [DWIDTH-1:0]   r_hold;
    logic [DWIDTH-1:0]   w_hold_nxt;
    logic [LANES_W-1:0]  r_hold_lanes;
    logic [LANES_W-1:0]  w_hold_lanes_nxt;

    logic [DWIDTH-1:0]   w_merged;
    logic                w_hold_valid;
    logic                w_wr_en;
    logic                w_ready;
    logic                w_accept;
    logic                w_complete;

    assign w_hold_valid = (r_state == ST_HELD);
    assign w_wr_en      = w_hold_valid && !bus.fifo_wr_full;
    assign w_ready      = !(w_hold_valid && bus.fifo_wr_full);
    assign w_accept     = bus.s_valid && w_ready;
    assign w_complete   = w_accept && ((r_lane == LANE_W'(RATIO - 1)) || bus.s_last);

    assign bus.s_ready      = w_ready;
    assign bus.fifo_wr_en   = w_wr_en;
    assign bus.fifo_wr_data = r_hold;
    assign bus.fifo_lanes   = w_hold_valid ? r_hold_lanes : '0;

    // Accumulator with the incoming beat dropped into the current lane.
    always_comb begin
        w_merged = r_acc;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (r_lane == LANE_W'(k)) begin
                w_merged[k*IN_WIDTH +: IN_WIDTH] = bus.s_data;
            end
        end
    end

    // Next-state: pack beats, hand finished words to the hold register, drain on write.
    always_comb begin
        w_state_nxt      = r_state;
        w_acc_nxt        = r_acc;
        w_lane_nxt       = r_lane;
        w_hold_nxt       = r_hold;
        w_hold_lanes_nxt = r_hold_lanes;

        if (w_complete) begin
            // Only reachable when the hold register is empty or draining this cycle.
            w_hold_nxt       = w_merged;
            w_hold_lanes_nxt = LANES_W'(r_lane) + LANES_W'(1);
            w_acc_nxt        = '0;
            w_lane_nxt       = '0;
            w_state_nxt      = ST_HELD;
        end else begin
            if (w_accept) begin
                w_acc_nxt  = w_merged;
                w_lane_nxt = r_lane + LANE_W'(1);
            end
            if (w_wr_en) begin
                w_state_nxt = ST_OPEN;
            end
        end
    end

    // State and datapath registers; reset discards partial and held words.
    always_ff @(posedge wr_clk_int or posedge rst) begin
        if (rst) begin
            r_state      <= ST_OPEN;
            r_acc        <= '0;
            r_lane       <= '0;
            r_hold       <= '0;
            r_hold_lanes <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_acc        <= w_acc_nxt;
            r_lane       <= w_lane_nxt;
            r_hold       <= w_hold_nxt;
            r_hold_lanes <= w_hold_lanes_nxt;
        end
    end

`ifdef WR_PACKER_WORD_CNT_EN
    logic [31:0] r_word_cnt;

    // Free-running count of FIFO writes, wraps naturally.
    always_ff @(posedge wr_clk_int or posedge rst) begin
        if (rst) begin
            r_word_cnt <= '0;
        end else if (w_wr_en) begin
            r_word_cnt <= r_word_cnt + 32'd1;
        end
    end

    assign wr_word_cnt = r_word_cnt;
`endif

endmodule
